// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD scheduler slice.
// Latency: none (declarations only).
// Backpressure: not applicable.
package gcd_pkg;

  // Sequencer states for the shared subtract-based GCD datapath.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CMP  = 3'd2,
    SUBX = 3'd3,
    SUBY = 3'd4,
    DONE = 3'd5,
    RESP = 3'd6
  } gcd_sched_state_t;

  // Datapath X/Y register input mux selects.
  localparam logic SEL_IN  = 1'b0;  // load from the registered operand
  localparam logic SEL_SUB = 1'b1;  // load from the subtractor

  // Default configuration.
  localparam int DEF_WIDTH = 8;
  localparam int DEF_N_REQ = 4;

endpackage

// File: rtl/gcd_rr_arb.sv
// Round-robin arbiter: picks the first requester after the pointer, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller samples the grant only when it can start a job.
module gcd_rr_arb #(
  parameter int N_REQ = 4,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PW-1:0]    idx,
  output logic             any
);

  // Candidate index ptr+i, wrapped into 0..N_REQ-1 (N_REQ need not be a power of two).
  function automatic logic [PW-1:0] cand(input logic [PW-1:0] p, input int i);
    int s;
    s = int'(p) + i;
    if (s >= N_REQ) s = s - N_REQ;
    return PW'(s);
  endfunction

  // Scan from ptr+1 around to ptr itself; the first set request wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!any && req[cand(ptr, i)]) begin
        any              = 1'b1;
        idx              = cand(ptr, i);
        gnt[cand(ptr, i)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gcd_sched.sv
// Round-robin scheduler/sequencer sharing one subtract-based GCD datapath; timeout via GCD_SCHED_TIMEOUT_EN.
// Latency: ack at cycle 4+2k for k subtraction steps (cycle 2 when an operand is zero), from the granting IDLE cycle.
// Backpressure: requesters hold req and operands until ack; new grants only in IDLE, so at most one job in flight.
module gcd_sched
  import gcd_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_ITER = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       rsp_d,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [WIDTH-1:0]       dp_xin,
  output logic [WIDTH-1:0]       dp_yin,
  output logic                   dp_xsel,
  output logic                   dp_ysel,
  output logic                   dp_xld,
  output logic                   dp_yld,
  output logic                   dp_dld,
  input  logic                   dp_eq,
  input  logic                   dp_lt,
  input  logic [WIDTH-1:0]       dp_x
);

  localparam int PW = $clog2(N_REQ);

  gcd_sched_state_t state_q, state_d;

  logic [PW-1:0]    ptr_q;      // last requester served
  logic [PW-1:0]    grant_q;    // requester owning the current job
  logic [WIDTH-1:0] xin_q;
  logic [WIDTH-1:0] yin_q;
  logic             byp_q;      // job has a zero operand, skip the datapath
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [PW-1:0]    arb_idx;
  logic             arb_any;

  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic             start_job;
  logic             tmo;        // iteration budget exhausted in CMP
  logic             job_err;    // current job ended on timeout

  gcd_rr_arb #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        a_sel = a_sel | a_in[i*WIDTH +: WIDTH];
        b_sel = b_sel | b_in[i*WIDTH +: WIDTH];
      end
    end
  end

  assign start_job = (state_q == IDLE) && arb_any;

`ifdef GCD_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(MAX_ITER + 1);

  logic [CW-1:0] iter_q;
  logic          err_q;

  assign tmo     = (iter_q == CW'(MAX_ITER)) && !dp_eq;
  assign job_err = err_q;

  // Subtraction step counter and sticky timeout flag for the current job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == LOAD) begin
        iter_q <= '0;
      end else if ((state_q == SUBX) || (state_q == SUBY)) begin
        iter_q <= iter_q + 1'b1;
      end
      if (start_job) begin
        err_q <= 1'b0;
      end else if ((state_q == CMP) && tmo) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  logic unused_max_iter;

  assign unused_max_iter = ^(32'(MAX_ITER));
  assign tmo             = 1'b0;
  assign job_err         = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and datapath control decode from the registered state.
  always_comb begin
    state_d = state_q;
    dp_xsel = SEL_IN;
    dp_ysel = SEL_IN;
    dp_xld  = 1'b0;
    dp_yld  = 1'b0;
    dp_dld  = 1'b0;
    ack     = '0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d = ((a_sel == '0) || (b_sel == '0)) ? DONE : LOAD;
        end
      end
      LOAD: begin
        dp_xld  = 1'b1;
        dp_yld  = 1'b1;
        state_d = CMP;
      end
      CMP: begin
        if (dp_eq || tmo) begin
          state_d = DONE;
        end else if (dp_lt) begin
          state_d = SUBY;
        end else begin
          state_d = SUBX;
        end
      end
      SUBX: begin
        dp_xsel = SEL_SUB;
        dp_xld  = 1'b1;
        state_d = CMP;
      end
      SUBY: begin
        dp_ysel = SEL_SUB;
        dp_yld  = 1'b1;
        state_d = CMP;
      end
      DONE: begin
        dp_dld  = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        ack[grant_q] = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Result source: bypass value for a zero operand, 0 on timeout, else the converged X.
  always_comb begin
    result_d = dp_x;
    if (byp_q) begin
      result_d = xin_q | yin_q;
    end else if (job_err) begin
      result_d = '0;
    end
  end

  // Grant/operand capture, result register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= PW'(N_REQ - 1);
      grant_q  <= '0;
      xin_q    <= '0;
      yin_q    <= '0;
      byp_q    <= 1'b0;
      result_q <= '0;
    end else begin
      if (start_job) begin
        grant_q <= arb_idx;
        xin_q   <= a_sel;
        yin_q   <= b_sel;
        byp_q   <= (a_sel == '0) || (b_sel == '0);
      end
      if (state_q == DONE) begin
        result_q <= result_d;
      end
      if (state_q == RESP) begin
        ptr_q <= grant_q;
      end
    end
  end

  assign dp_xin  = xin_q;
  assign dp_yin  = yin_q;
  assign rsp_d   = result_q;
  assign rsp_err = (state_q == RESP) && job_err;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_gcd_sched.sv
// Self-checking bench for gcd_sched with a behavioural GCD datapath and a job-level reference model.
// Latency: checks ack cycle against 4+2k (2 for zero operands) counted from the granting IDLE cycle.
// Backpressure: requesters hold req until ack, then drop it in the ack cycle unless testing hold-over.
module tb_gcd_sched;

`ifdef GCD_SCHED_TIMEOUT_EN
  localparam int MI = 4;
`else
  localparam int MI = 255;
`endif
  localparam int NR = 4;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req = '0;
  logic [NR*W-1:0] a_in = '0;
  logic [NR*W-1:0] b_in = '0;
  logic [NR-1:0]   ack;
  logic [W-1:0]    rsp_d;
  logic            rsp_err, busy;
  logic [W-1:0]    dp_xin, dp_yin;
  logic            dp_xsel, dp_ysel, dp_xld, dp_yld, dp_dld;
  logic            dp_eq, dp_lt;
  logic [W-1:0]    dp_x;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gcd_sched #(.N_REQ(NR), .WIDTH(W), .MAX_ITER(MI)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
    .ack(ack), .rsp_d(rsp_d), .rsp_err(rsp_err), .busy(busy),
    .dp_xin(dp_xin), .dp_yin(dp_yin), .dp_xsel(dp_xsel), .dp_ysel(dp_ysel),
    .dp_xld(dp_xld), .dp_yld(dp_yld), .dp_dld(dp_dld),
    .dp_eq(dp_eq), .dp_lt(dp_lt), .dp_x(dp_x)
  );

  // Shared GCD datapath: X/Y registers with subtractor, plus comparator flags.
  logic [W-1:0] x_r = '0;
  logic [W-1:0] y_r = '0;
  always_ff @(posedge clk) begin
    if (dp_xld) x_r <= dp_xsel ? (x_r - y_r) : dp_xin;
    if (dp_yld) y_r <= dp_ysel ? (y_r - x_r) : dp_yin;
  end
  assign dp_eq = (x_r == y_r);
  assign dp_lt = (x_r < y_r);
  assign dp_x  = x_r;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Job-level reference: subtractive GCD step count, bypass for zero operands, optional step budget.
  function automatic void ref_job(input int a, input int b, output int res, output int err,
                                  output int k, output int lat);
    int x, y;
    err = 0;
    k   = 0;
    if (a == 0 || b == 0) begin
      res = a | b;
      lat = 2;
      return;
    end
    x = a;
    y = b;
    while (x != y) begin
`ifdef GCD_SCHED_TIMEOUT_EN
      if (k == MI) begin
        err = 1;
        break;
      end
`endif
      if (x > y) x = x - y; else y = y - x;
      k++;
    end
    res = err ? 0 : x;
    lat = 4 + 2 * k;
  endfunction

  task automatic set_ops(input int r, input int a, input int b);
    a_in[r*W +: W] = W'(a);
    b_in[r*W +: W] = W'(b);
  endtask

  // Wait for the ack of requester r's job (a,b); current cycle is cycle 0.
  task automatic wait_ack(input string tag, input int r, input int a, input int b, input bit drop);
    int res, err, k, lat;
    int n, subs, loads;
    bit got;
    ref_job(a, b, res, err, k, lat);
    n = 0; subs = 0; loads = 0; got = 1'b0;
    while (!got && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      if ((dp_xld && dp_xsel) || (dp_yld && dp_ysel)) subs++;
      if (dp_xld && !dp_xsel) loads++;
      if (ack != '0) got = 1'b1;
    end
    check({tag, "_ack_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, "_ack_onehot"}, 32'(ack), 32'(1 << r));
      check({tag, "_rsp_d"}, 32'(rsp_d), 32'(res));
      check({tag, "_rsp_err"}, 32'(rsp_err), 32'(err));
      check({tag, "_latency"}, 32'(n), 32'(lat));
      check({tag, "_sub_steps"}, 32'(subs), 32'(k));
      check({tag, "_x_loads"}, 32'(loads), (a == 0 || b == 0) ? 32'd0 : 32'd1);
      if (drop) req[r] = 1'b0;
      @(posedge clk);
      #1;
      check({tag, "_ack_pulse"}, 32'(ack), 32'd0);
      check({tag, "_rsp_hold"}, 32'(rsp_d), 32'(res));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", 32'({ack, rsp_err, busy, dp_xsel, dp_ysel, dp_xld, dp_yld, dp_dld}), 32'd0);
    check("rst_rsp_d", 32'(rsp_d), 32'd0);
    check("rst_xin_yin", 32'({dp_xin, dp_yin}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int ptr, exp_r, a, b, r, n;
    bit found;

    // Reset state.
    do_reset();

    // Directed single jobs.
    set_ops(1, 12, 18);  req[1] = 1'b1; wait_ack("r1_12_18", 1, 12, 18, 1'b1);
    set_ops(0, 7, 7);    req[0] = 1'b1; wait_ack("r0_7_7", 0, 7, 7, 1'b1);
    set_ops(2, 0, 9);    req[2] = 1'b1; wait_ack("r2_0_9", 2, 0, 9, 1'b1);
    set_ops(3, 0, 0);    req[3] = 1'b1; wait_ack("r3_0_0", 3, 0, 0, 1'b1);
    set_ops(0, 1, 200);  req[0] = 1'b1; wait_ack("r0_1_200", 0, 1, 200, 1'b1);
    check("idle_busy", 32'(busy), 32'd0);

    // Randomized single jobs, with zero operands mixed in.
    for (int j = 0; j < 12; j++) begin
      r = $urandom_range(0, NR - 1);
      a = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      set_ops(r, a, b);
      req[r] = 1'b1;
      wait_ack($sformatf("rand%0d", j), r, a, b, 1'b1);
    end

    // Round-robin with all requesters held high from a fresh reset.
    do_reset();
    for (int i = 0; i < NR; i++) set_ops(i, 10 + i, 10 + i);
    req = '1;
    ptr = NR - 1;
    for (int j = 0; j < 6; j++) begin
      exp_r = (ptr + 1) % NR;
      ptr   = exp_r;
      wait_ack($sformatf("rr%0d", j), exp_r, 10 + exp_r, 10 + exp_r, 1'b0);
    end
    req = '0;
    repeat (8) @(posedge clk);
    #1;
    check("rr_drained_busy", 32'(busy), 32'd0);

    // Reset asserted during a SUBX cycle aborts the job; held request is re-served.
    do_reset();
    set_ops(0, 200, 3);
    req[0] = 1'b1;
    found = 1'b0;
    n = 0;
    while (!found && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (dp_xld && dp_xsel) found = 1'b1;
    end
    check("midrst_subx_seen", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl_zero", 32'({ack, busy, dp_xld, dp_yld, dp_dld, rsp_err}), 32'd0);
    check("midrst_xin_zero", 32'(dp_xin), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ack("midrst_reserve", 0, 200, 3, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
